// File: rtl/load_store_unit.sv
// Load/store stage: one single-outstanding bus transaction per load or store, with lane
// steering, load extension and core stall. Optional LSU_MISALIGN_TRAP_EN faults misaligned half/word.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; illegal requests go straight to DONE
// BUS   | bus_req held with stable bus_* until bus_ready
// DONE  | done pulse, load_data valid, stall released for one core advance
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_w_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        access_req;
    logic        is_half;
    logic        is_word;
    logic        f3_legal;
    logic        misalign;
    logic        illegal;
    logic [1:0]  off;
    logic [1:0]  eff_off;
    logic [1:0]  size_d;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;

    logic        start_bus;
    logic        start_fault;
    logic        bus_hs;

    logic [1:0]  req_off;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    assign access_req = mem_read | mem_write;
    assign off        = mem_addr[1:0];
    assign is_half    = (func3[1:0] == 2'b01);
    assign is_word    = (func3 == 3'b010);

    always_comb begin
        f3_legal = 1'b0;
        case (func3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = ~mem_write;
            default:                f3_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (is_half & off[0]) | (is_word & (off != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign illegal = (mem_read & mem_write) | ~f3_legal | misalign;

    // Without the trap, half/word addresses silently drop the low offset bits.
    always_comb begin
        eff_off = off;
        size_d  = 2'd0;
        if (is_word) begin
            eff_off = 2'b00;
            size_d  = 2'd2;
        end else if (is_half) begin
            eff_off = {off[1], 1'b0};
            size_d  = 2'd1;
        end
    end

    always_comb begin
        wstrb_d = 4'b0000;
        wdata_d = 32'h0000_0000;
        if (mem_write) begin
            if (is_word) begin
                wstrb_d = 4'b1111;
                wdata_d = mem_w_data;
            end else if (is_half) begin
                wstrb_d = 4'b0011 << eff_off;
                wdata_d = {2{mem_w_data[15:0]}};
            end else begin
                wstrb_d = 4'b0001 << eff_off;
                wdata_d = {4{mem_w_data[7:0]}};
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        start_bus   = 1'b0;
        start_fault = 1'b0;
        bus_hs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_req) begin
                    if (illegal) begin
                        state_d     = DONE;
                        start_fault = 1'b1;
                    end else begin
                        state_d   = BUS;
                        start_bus = 1'b1;
                    end
                end
            end
            BUS: begin
                if (bus_ready) begin
                    state_d = DONE;
                    bus_hs  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall = ((state_q == IDLE) & access_req) | (state_q == BUS);
    assign done  = (state_q == DONE);

    always_comb begin
        byte_sel = bus_rdata[7:0];
        case (req_off)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = req_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (req_size)
            2'd0:    ext_data = {{24{~req_unsigned & byte_sel[7]}}, byte_sel};
            2'd1:    ext_data = {{16{~req_unsigned & half_sel[15]}}, half_sel};
            default: ext_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'h0000_0000;
            bus_wstrb    <= 4'b0000;
            bus_wdata    <= 32'h0000_0000;
            load_data    <= 32'h0000_0000;
            fault        <= 1'b0;
            req_off      <= 2'b00;
            req_size     <= 2'd0;
            req_unsigned <= 1'b0;
        end else begin
            fault <= start_fault;
            if (start_bus) begin
                bus_req      <= 1'b1;
                bus_we       <= mem_write;
                bus_addr     <= {mem_addr[31:2], 2'b00};
                bus_wstrb    <= wstrb_d;
                bus_wdata    <= wdata_d;
                req_off      <= eff_off;
                req_size     <= size_d;
                req_unsigned <= func3[2];
            end else if (bus_hs) begin
                bus_req <= 1'b0;
            end
            if (bus_hs) begin
                load_data <= ext_data;
            end else if (start_fault) begin
                load_data <= 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed test-plan cases plus randomized accesses
// checked against a byte/width arithmetic model of the access rules.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic        stall;
    logic [31:0] load_data;
    logic        done;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int n_total = 0;
    int n_pass  = 0;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .func3      (func3),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .stall      (stall),
        .load_data  (load_data),
        .done       (done),
        .fault      (fault),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Access rules as arithmetic: width in bytes, offset within the word.
    function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] rs2,
                                  input logic [31:0] rdata,
                                  output logic f, output logic [31:0] a,
                                  output logic [3:0] s, output logic [31:0] wd,
                                  output logic [31:0] ld);
        int          width;
        int          o;
        bit          sgn;
        bit          legal;
        logic [31:0] mask;
        logic [31:0] field;
        width = 4;
        sgn   = 0;
        legal = 0;
        case (f3)
            3'd0: begin width = 1; sgn = 1; legal = 1; end
            3'd1: begin width = 2; sgn = 1; legal = 1; end
            3'd2: begin width = 4; legal = 1; end
            3'd4: begin width = 1; legal = rd && !wr; end
            3'd5: begin width = 2; legal = rd && !wr; end
            default: legal = 0;
        endcase
        if (rd && wr) legal = 0;
        o = int'(addr % 4);
`ifdef LSU_MISALIGN_TRAP_EN
        if (legal && (o % width) != 0) legal = 0;
`else
        o = o - (o % width);
`endif
        f  = !legal;
        a  = addr - (addr % 4);
        s  = wr ? 4'(((1 << width) - 1) << o) : 4'b0000;
        if (!wr)             wd = 32'h0;
        else if (width == 1) wd = 32'(rs2[7:0]) * 32'h0101_0101;
        else if (width == 2) wd = 32'(rs2[15:0]) * 32'h0001_0001;
        else                 wd = rs2;
        mask  = (width == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * width)) - 32'd1;
        field = (rdata >> (8 * o)) & mask;
        if (sgn && width < 4 && field[8 * width - 1]) field = field | ~mask;
        ld = f ? 32'h0 : field;
    endfunction

    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rs2, input logic [31:0] rdata,
                              input int waits);
        logic        ef;
        logic [31:0] ea;
        logic [3:0]  es;
        logic [31:0] ewd;
        logic [31:0] eld;
        model(rd, wr, f3, addr, rs2, rdata, ef, ea, es, ewd, eld);
        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        func3      = f3;
        mem_addr   = addr;
        mem_w_data = rs2;
        bus_ready  = 1'($urandom_range(0, 1));
        bus_rdata  = $urandom;
        #1;
        chk({tag, " stall c0"}, 32'(stall), 32'd1);
        chk({tag, " req c0"}, 32'(bus_req), 32'd0);
        if (!ef) begin
            for (int i = 0; i <= waits; i++) begin
                @(negedge clk);
                chk({tag, " req"}, 32'(bus_req), 32'd1);
                chk({tag, " stall bus"}, 32'(stall), 32'd1);
                chk({tag, " done bus"}, 32'(done), 32'd0);
                chk({tag, " we"}, 32'(bus_we), 32'(wr));
                chk({tag, " addr"}, bus_addr, ea);
                chk({tag, " wstrb"}, 32'(bus_wstrb), 32'(es));
                chk({tag, " wdata"}, bus_wdata, ewd);
                bus_ready = (i == waits);
                bus_rdata = (i == waits) ? rdata : $urandom;
            end
        end
        @(negedge clk);
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " fault"}, 32'(fault), 32'(ef));
        chk({tag, " stall done"}, 32'(stall), 32'd0);
        chk({tag, " req done"}, 32'(bus_req), 32'd0);
        if (rd || ef) chk({tag, " load_data"}, load_data, eld);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk({tag, " done idle"}, 32'(done), 32'd0);
        chk({tag, " fault idle"}, 32'(fault), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        func3      = 3'd0;
        mem_addr   = 32'h0;
        mem_w_data = 32'h0;
        bus_ready  = 1'b0;
        bus_rdata  = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst bus_req", 32'(bus_req), 32'd0);
        chk("rst bus_we", 32'(bus_we), 32'd0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chk("rst bus_wstrb", 32'(bus_wstrb), 32'h0);
        chk("rst bus_wdata", bus_wdata, 32'h0);
        chk("rst load_data", load_data, 32'h0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst fault", 32'(fault), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);

        run_access("sw",  0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        run_access("sb",  0, 1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0);
        run_access("sh",  0, 1, 3'd1, 32'h102, 32'h00001234, 32'h0, 0);
        run_access("lb",  1, 0, 3'd0, 32'h201, 32'h0, 32'h00008000, 0);
        run_access("lbu", 1, 0, 3'd4, 32'h201, 32'h0, 32'h00008000, 0);
        run_access("lh",  1, 0, 3'd1, 32'h202, 32'h0, 32'h80010000, 0);
        run_access("lhu", 1, 0, 3'd5, 32'h202, 32'h0, 32'h80010000, 1);
        run_access("lw3", 1, 0, 3'd2, 32'h204, 32'h0, 32'hCAFEF00D, 3);
        run_access("lwmis", 1, 0, 3'd2, 32'h301, 32'h0, 32'h11223344, 0);
        run_access("shmis", 0, 1, 3'd1, 32'h303, 32'hBEEF, 32'h0, 1);
        run_access("sbu", 0, 1, 3'd4, 32'h310, 32'h55, 32'h0, 0);
        run_access("f3_7", 1, 0, 3'd7, 32'h320, 32'h0, 32'h0, 0);
        run_access("rw", 1, 1, 3'd2, 32'h330, 32'h1, 32'h2, 0);

        // Reset in the second BUS cycle aborts the load; a stale bus_ready must not complete it.
        @(negedge clk);
        mem_read  = 1'b1;
        func3     = 3'd2;
        mem_addr  = 32'h400;
        bus_ready = 1'b0;
        @(negedge clk);
        chk("abort req bus1", 32'(bus_req), 32'd1);
        @(negedge clk);
        chk("abort req bus2", 32'(bus_req), 32'd1);
        rst       = 1'b0;
        mem_read  = 1'b0;
        bus_ready = 1'b1;
        @(negedge clk);
        chk("abort req", 32'(bus_req), 32'd0);
        chk("abort stall", 32'(stall), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort no done", 32'(done), 32'd0);
            chk("abort no req", 32'(bus_req), 32'd0);
        end

        for (int n = 0; n < 60; n++) begin
            logic rd;
            logic wr;
            int   kind;
            kind = $urandom_range(0, 9);
            rd   = (kind == 0) || (kind <= 5);
            wr   = (kind == 0) || (kind > 5);
            run_access("rand", rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
                       $urandom, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
